// File: rtl/univ_shift_reg.sv
// -----------------------------------------------------------------------------
// univ_shift_reg
// Universal shift register with parallel load, logical shifts, rotates,
// arithmetic shift right and clear. A saturating counter tracks how many
// shift/rotate operations have happened since the last load or clear.
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous active-high reset (priority over everything)
//   en         operation enable; when low all state holds
//   mode[2:0]  000 hold, 001 load, 010 shl, 011 shr,
//              100 rotl, 101 rotr, 110 asr, 111 clear
//   d          parallel load data
//   sin_r      serial input entering bit 0 on shl
//   sin_l      serial input entering bit WIDTH-1 on shr
//   q          register contents
//   qbar       bitwise complement of q
//   sout_l     q[WIDTH-1]
//   sout_r     q[0]
//   shift_cnt  shifts/rotates since last load or clear, saturating at WIDTH
//   drained    shift_cnt == WIDTH
// -----------------------------------------------------------------------------
module univ_shift_reg #(
    parameter  int WIDTH = 8,
    localparam int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [2:0]       mode,
    input  logic [WIDTH-1:0] d,
    input  logic             sin_r,
    input  logic             sin_l,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qbar,
    output logic             sout_l,
    output logic             sout_r,
    output logic [CNT_W-1:0] shift_cnt,
    output logic             drained
);

    localparam logic [2:0] MODE_HOLD  = 3'b000;
    localparam logic [2:0] MODE_LOAD  = 3'b001;
    localparam logic [2:0] MODE_SHL   = 3'b010;
    localparam logic [2:0] MODE_SHR   = 3'b011;
    localparam logic [2:0] MODE_ROTL  = 3'b100;
    localparam logic [2:0] MODE_ROTR  = 3'b101;
    localparam logic [2:0] MODE_ASR   = 3'b110;
    localparam logic [2:0] MODE_CLEAR = 3'b111;

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(WIDTH);

    logic [WIDTH-1:0] q_next;
    logic [CNT_W-1:0] cnt_next;
    logic             is_shift;
    logic             cnt_zero;

    always_comb begin
        q_next   = q;
        is_shift = 1'b0;
        cnt_zero = 1'b0;
        case (mode)
            MODE_HOLD:  q_next = q;
            MODE_LOAD: begin
                q_next   = d;
                cnt_zero = 1'b1;
            end
            MODE_SHL: begin
                q_next   = {q[WIDTH-2:0], sin_r};
                is_shift = 1'b1;
            end
            MODE_SHR: begin
                q_next   = {sin_l, q[WIDTH-1:1]};
                is_shift = 1'b1;
            end
            MODE_ROTL: begin
                q_next   = {q[WIDTH-2:0], q[WIDTH-1]};
                is_shift = 1'b1;
            end
            MODE_ROTR: begin
                q_next   = {q[0], q[WIDTH-1:1]};
                is_shift = 1'b1;
            end
            MODE_ASR: begin
                q_next   = {q[WIDTH-1], q[WIDTH-1:1]};
                is_shift = 1'b1;
            end
            MODE_CLEAR: begin
                q_next   = '0;
                cnt_zero = 1'b1;
            end
            default:    q_next = q;
        endcase
    end

    // Counter saturates so drained stays asserted through further rotates.
    always_comb begin
        cnt_next = shift_cnt;
        if (cnt_zero) begin
            cnt_next = '0;
        end else if (is_shift && (shift_cnt != CNT_MAX)) begin
            cnt_next = shift_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            q         <= '0;
            shift_cnt <= '0;
        end else if (en) begin
            q         <= q_next;
            shift_cnt <= cnt_next;
        end
    end

    assign qbar    = ~q;
    assign sout_l  = q[WIDTH-1];
    assign sout_r  = q[0];
    assign drained = (shift_cnt == CNT_MAX);

endmodule

// File: tb/tb_univ_shift_reg.sv
// -----------------------------------------------------------------------------
// tb_univ_shift_reg
// Directed scenarios with literal expectations, followed by randomized
// operation against an arithmetic reference model. Outputs are compared to
// the model on every falling edge once the first reset has been applied.
// -----------------------------------------------------------------------------
module tb_univ_shift_reg;

    localparam int W = 8;

    logic         clk;
    logic         rst;
    logic         en;
    logic [2:0]   mode;
    logic [W-1:0] d;
    logic         sin_r;
    logic         sin_l;
    logic [W-1:0] q;
    logic [W-1:0] qbar;
    logic         sout_l;
    logic         sout_r;
    logic [3:0]   shift_cnt;
    logic         drained;

    int total = 0;
    int bad   = 0;

    // reference model state
    int unsigned m_q     = 0;
    int unsigned m_cnt   = 0;
    bit          m_valid = 0;

    univ_shift_reg #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .mode      (mode),
        .d         (d),
        .sin_r     (sin_r),
        .sin_l     (sin_l),
        .q         (q),
        .qbar      (qbar),
        .sout_l    (sout_l),
        .sout_r    (sout_r),
        .shift_cnt (shift_cnt),
        .drained   (drained)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: operations expressed as plain integer arithmetic on an 8-bit value.
    always @(posedge clk) begin
        if (rst) begin
            m_q     = 0;
            m_cnt   = 0;
            m_valid = 1;
        end else if (en && m_valid) begin
            case (mode)
                3'd0: ;
                3'd1: begin m_q = d;  m_cnt = 0; end
                3'd2: m_q = ((m_q * 2) + sin_r) % 256;
                3'd3: m_q = (m_q / 2) + (sin_l ? 128 : 0);
                3'd4: m_q = ((m_q * 2) % 256) + (m_q / 128);
                3'd5: m_q = (m_q / 2) + ((m_q % 2) * 128);
                3'd6: m_q = (m_q / 2) + (m_q >= 128 ? 128 : 0);
                3'd7: begin m_q = 0;  m_cnt = 0; end
                default: ;
            endcase
            if (mode >= 3'd2 && mode <= 3'd6 && m_cnt < W) m_cnt = m_cnt + 1;
        end
    end

    always @(negedge clk) begin
        if (m_valid) begin
            chk("q",         q,         m_q);
            chk("qbar",      qbar,      255 - m_q);
            chk("sout_l",    sout_l,    m_q / 128);
            chk("sout_r",    sout_r,    m_q % 2);
            chk("shift_cnt", shift_cnt, m_cnt);
            chk("drained",   drained,   m_cnt == W);
        end
    end

    task automatic cyc(input logic r, input logic e, input logic [2:0] m,
                       input logic [7:0] dv, input logic sl, input logic sr);
        rst   = r;
        en    = e;
        mode  = m;
        d     = dv;
        sin_l = sl;
        sin_r = sr;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; en = 1'b1; mode = 3'd1; d = 8'hA5; sin_l = 1'b0; sin_r = 1'b0;

        // reset beats a load
        cyc(1, 1, 3'd1, 8'hA5, 0, 0);
        chk("rst_q",       q,         8'h00);
        chk("rst_qbar",    qbar,      8'hFF);
        chk("rst_cnt",     shift_cnt, 4'd0);
        chk("rst_drained", drained,   1'b0);
        chk("rst_souts",   {sout_l, sout_r}, 2'b00);

        // load then shl
        cyc(0, 1, 3'd1, 8'hA5, 0, 0);
        chk("pre_shl_sout_l", sout_l, 1'b1);
        cyc(0, 1, 3'd2, 8'h00, 0, 1);
        chk("shl_q",   q,         8'h4B);
        chk("shl_cnt", shift_cnt, 4'd1);

        // full rotation returns the loaded value
        cyc(0, 1, 3'd1, 8'h3C, 0, 0);
        for (int i = 0; i < W; i++) cyc(0, 1, 3'd4, 8'h00, 0, 0);
        chk("rotl8_q",       q,         8'h3C);
        chk("rotl8_cnt",     shift_cnt, 4'd8);
        chk("rotl8_drained", drained,   1'b1);
        cyc(0, 1, 3'd4, 8'h00, 0, 0);
        chk("rotl9_q",   q,         8'h78);
        chk("rotl9_cnt", shift_cnt, 4'd8);

        // arithmetic shift right, then logical shr
        cyc(0, 1, 3'd1, 8'h80, 0, 0);
        cyc(0, 1, 3'd6, 8'h00, 0, 0);
        chk("asr1", q, 8'hC0);
        cyc(0, 1, 3'd6, 8'h00, 0, 0);
        chk("asr2", q, 8'hE0);
        cyc(0, 1, 3'd6, 8'h00, 0, 0);
        chk("asr3", q, 8'hF0);
        cyc(0, 1, 3'd3, 8'h00, 0, 0);
        chk("shr_q",   q,         8'h78);
        chk("shr_cnt", shift_cnt, 4'd4);

        // enable low holds everything
        cyc(0, 1, 3'd1, 8'h5A, 0, 0);
        cyc(0, 1, 3'd5, 8'h00, 0, 0);
        cyc(0, 1, 3'd4, 8'h00, 0, 0);
        for (int i = 0; i < 3; i++) cyc(0, 0, 3'd1, 8'hFF, 1, 1);
        chk("en0_q",   q,         8'h5A);
        chk("en0_cnt", shift_cnt, 4'd2);

        // reset mid-sequence
        cyc(0, 1, 3'd1, 8'hFF, 0, 0);
        for (int i = 0; i < 3; i++) cyc(0, 1, 3'd2, 8'h00, 0, 0);
        chk("pre_rst_q", q, 8'hF8);
        cyc(1, 1, 3'd2, 8'h00, 1, 1);
        chk("midrst_q",   q,         8'h00);
        chk("midrst_cnt", shift_cnt, 4'd0);
        cyc(0, 1, 3'd1, 8'h11, 0, 0);
        chk("post_rst_load", q, 8'h11);

        // randomized operation against the model
        for (int i = 0; i < 3000; i++) begin
            cyc(($urandom_range(0, 99) == 0),
                ($urandom_range(0, 3) != 0),
                3'($urandom_range(0, 7)),
                8'($urandom),
                1'($urandom),
                1'($urandom));
        end

        // long rotr run to exercise saturation in random context
        cyc(0, 1, 3'd1, 8'h96, 0, 0);
        for (int i = 0; i < 10; i++) cyc(0, 1, 3'd5, 8'h00, 0, 0);
        chk("rotr10_q",   q,         8'hA5);
        chk("rotr10_cnt", shift_cnt, 4'd8);

        @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/univ_shift_reg.md
UNIV_SHIFT_REG -- requirements
Module: univ_shift_reg

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the register width in bits; legal range 2..64.
REQ-002 The block SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-004 The block SHALL have port en, input, 1 bit: operation enable; when 0 the register, counter and flags hold.
REQ-005 The block SHALL have port mode, input, 3 bits: operation select per REQ-014.
REQ-006 The block SHALL have port d, input, WIDTH bits: parallel load data.
REQ-007 The block SHALL have port sin_r, input, 1 bit: serial data entering bit 0 on a left shift.
REQ-008 The block SHALL have port sin_l, input, 1 bit: serial data entering bit WIDTH-1 on a right shift.
REQ-009 The block SHALL have port q, output, WIDTH bits: register contents.
REQ-010 The block SHALL have port qbar, output, WIDTH bits: bitwise complement of q at all times.
REQ-011 The block SHALL have ports sout_l and sout_r, outputs, 1 bit each: equal to q[WIDTH-1] and q[0] respectively.
REQ-012 The block SHALL have port shift_cnt, output, clog2(WIDTH)+1 bits: shifts/rotates performed since the last load or clear.
REQ-013 The block SHALL have port drained, output, 1 bit: high when shift_cnt == WIDTH.

Function
REQ-014 The block SHALL apply these modes on each rising edge with en=1: 000 hold; 001 load (q<=d); 010 shl (q<={q[W-2:0],sin_r}); 011 shr (q<={sin_l,q[W-1:1]}); 100 rotl (q<={q[W-2:0],q[W-1]}); 101 rotr (q<={q[0],q[W-1:1]}); 110 asr (q<={q[W-1],q[W-1:1]}); 111 clear (q<=0).
REQ-015 The block SHALL update q exactly one cycle after the edge that samples en/mode; latency 1, no combinational path from d, sin_l or sin_r to q.
REQ-016 The block SHALL derive qbar, sout_l, sout_r and drained combinationally from registered state only.
REQ-017 The block SHALL clear shift_cnt to 0 on load or clear.
REQ-018 The block SHALL increment shift_cnt by 1 on each shl, shr, rotl, rotr or asr, saturating at WIDTH.
REQ-019 The block SHALL leave shift_cnt unchanged on hold and whenever en=0.
REQ-020 The block SHALL ignore mode, d and the serial inputs when en=0; all state holds.
REQ-021 The block SHALL sample sout_l/sout_r before a shift, so the bit shifted out equals sout_l/sout_r during the cycle preceding the edge.
REQ-022 The block SHALL produce, after WIDTH consecutive rotl (or rotr) operations following a load, a q equal to the loaded value with drained=1.

Reset
REQ-023 The block SHALL, on any edge with rst=1, set q=0, shift_cnt=0, giving qbar=all ones, drained=0, sout_l=sout_r=0.
REQ-024 rst SHALL take priority over en and every mode, including mid-sequence shifting.
REQ-025 The block SHALL have no asynchronous state; q is undefined before the first reset edge.

Verification (WIDTH=8)
REQ-026 A bench SHALL drive rst=1, en=1, mode=001, d=0xA5 for one edge -> q=0x00, qbar=0xFF, shift_cnt=0, drained=0.
REQ-027 A bench SHALL load 0xA5, then shl with sin_r=1 -> q=0x4B, shift_cnt=1; sout_l=1 in the cycle before the shift.
REQ-028 A bench SHALL load 0x3C, then apply 8 rotl -> q=0x3C, shift_cnt=8, drained=1; a 9th rotl -> q=0x78, shift_cnt stays 8.
REQ-029 A bench SHALL load 0x80, then apply asr three times -> 0xC0, 0xE0, 0xF0; shr with sin_l=0 from 0xF0 -> 0x78.
REQ-030 A bench SHALL hold en=0 with mode=001, d=0xFF after q=0x5A -> q stays 0x5A, shift_cnt unchanged.
REQ-031 A bench SHALL assert rst after 3 shifts of a loaded 0xFF -> next edge q=0x00, shift_cnt=0; the following load 0x11 -> q=0x11.
